// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU bus arbiter and related grant logic.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam logic [3:0]  BYTEEN_ALL      = 4'b1111;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [1:0]  GNT_NONE        = 2'b00;
  localparam logic [1:0]  GNT_I           = 2'b01;
  localparam logic [1:0]  GNT_D           = 2'b10;

endpackage

// File: rtl/bus_grant_picker.sv
// Combinational two-way grant choice: fixed D-over-I priority or round-robin on last_d.
module bus_grant_picker
  import mips_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_d,
  output logic [1:0] grant
);

  // One-hot grant; on a tie round-robin favours whoever was not served last.
  always_comb begin
    grant = GNT_NONE;
    if (i_req && d_req) begin
      if ((DATA_PRIORITY != 0) || !last_d) begin
        grant = GNT_D;
      end else begin
        grant = GNT_I;
      end
    end else if (d_req) begin
      grant = GNT_D;
    end else if (i_req) begin
      grant = GNT_I;
    end else begin
      grant = GNT_NONE;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the single Avalon master port between instruction fetch (I) and load/store (D).
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_done,
  output logic [31:0] i_readdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_done,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        busy
);

  arb_state_t  state_r;
  logic        last_d_r;
  logic [1:0]  grant_s;
  logic [31:0] address_r;
  logic [31:0] writedata_r;
  logic [3:0]  byteenable_r;
  logic        read_r;
  logic        write_r;

  bus_grant_picker #(.DATA_PRIORITY(DATA_PRIORITY)) u_picker (
    .i_req  (i_req),
    .d_req  (d_req),
    .last_d (last_d_r),
    .grant  (grant_s)
  );

  // Arbitration FSM; bus fields are latched on the grant edge and held until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_d_r     <= 1'b0;
      address_r    <= 32'h0000_0000;
      writedata_r  <= 32'h0000_0000;
      byteenable_r <= 4'b0000;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s == GNT_D) begin
            state_r      <= GRANT_D;
            address_r    <= d_address & WORD_ALIGN_MASK;
            read_r       <= !d_write;
            write_r      <= d_write;
            byteenable_r <= d_byteenable;
            writedata_r  <= d_writedata;
          end else if (grant_s == GNT_I) begin
            state_r      <= GRANT_I;
            address_r    <= i_address & WORD_ALIGN_MASK;
            read_r       <= 1'b1;
            write_r      <= 1'b0;
            byteenable_r <= BYTEEN_ALL;
            writedata_r  <= 32'h0000_0000;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT_I: begin
          if (!waitrequest) begin
            state_r  <= IDLE;
            read_r   <= 1'b0;
            write_r  <= 1'b0;
            last_d_r <= 1'b0;
          end
        end
        GRANT_D: begin
          if (!waitrequest) begin
            state_r  <= IDLE;
            read_r   <= 1'b0;
            write_r  <= 1'b0;
            last_d_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          read_r  <= 1'b0;
          write_r <= 1'b0;
        end
      endcase
    end
  end

  assign address    = address_r;
  assign writedata  = writedata_r;
  assign byteenable = byteenable_r;
  assign read       = read_r;
  assign write      = write_r;
  assign busy       = (state_r != IDLE);
  assign i_done     = (state_r == GRANT_I) && !waitrequest;
  assign d_done     = (state_r == GRANT_D) && !waitrequest;
  assign i_readdata = readdata;
  assign d_readdata = readdata;

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Shares the CPU's single Avalon memory-mapped master port between two internal requesters: the instruction-fetch unit (port I) and the load/store unit (port D). Each requester uses a simple req/done handshake. The arbiter picks one requester, registers its transaction onto the bus, holds it through `waitrequest`, and returns completion and read data. It sits between the CPU core datapath and the top-level Avalon bus pins.

## Interface
Parameters:
- `DATA_PRIORITY`, default 1: 1 means fixed priority, D over I; 0 means round-robin.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_req` input 1: fetch request; held high until `i_done`.
- `i_address` input 32: fetch byte address.
- `i_done` output 1: fetch completes this cycle.
- `i_readdata` output 32: fetched word; valid while `i_done`.
- `d_req` input 1: data request; held high until `d_done`.
- `d_write` input 1: 1 for store, 0 for load.
- `d_address` input 32: data byte address.
- `d_writedata` input 32: store data.
- `d_byteenable` input 4: store/load lane enables.
- `d_done` output 1: data transfer completes this cycle.
- `d_readdata` output 32: load word; valid while `d_done`.
- `address` output 32: Avalon address, word-aligned.
- `write` output 1: Avalon write strobe.
- `read` output 1: Avalon read strobe.
- `waitrequest` input 1: Avalon stall.
- `writedata` output 32: Avalon write data.
- `byteenable` output 4: Avalon lane enables.
- `readdata` input 32: Avalon read data.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - Only `i_req` high: go to GRANT_I.
  - Only `d_req` high: go to GRANT_D.
  - Both high: go to GRANT_D when `DATA_PRIORITY`=1. Otherwise grant the requester not served last (`last_d` flag; reset value 0, so D wins the first tie).
- On the grant edge, register the bus fields:
  - `address` = {req_address[31:2],2'b00}.
  - GRANT_I: `read`=1, `write`=0, `byteenable`=4'b1111, `writedata`=0.
  - GRANT_D: `read`=!d_write, `write`=d_write, `byteenable`=d_byteenable, `writedata`=d_writedata.
- Registered bus outputs stay constant for the whole grant, whatever happens on requester inputs.
- Completion is combinational: `x_done` = (state==GRANT_X) && !waitrequest.
- `x_readdata` = `readdata` passthrough. It is meaningful only while `x_done` is high for a read.
- Completion edge: state goes to IDLE, `read`/`write` are cleared, `last_d` is updated.
- Requesters drop `req` (or present a new request) the cycle after `done`. IDLE therefore never re-serves a completed request.
- A request that rises while the other port is granted waits in IDLE arbitration; it is not queued.
- A `req` that drops before `done` is a protocol violation. The arbiter completes the bus transfer anyway; `done` is still pulsed.

## Timing
- Reset (asynchronous, active-low): state=IDLE, `last_d`=0, `read`=`write`=0, `address`=0, `writedata`=0, `byteenable`=0, `busy`=0, both `done`=0. The outputs clear immediately, including mid-transfer; a transfer aborted by reset is not completed.
- Minimum latency: `req` high in cycle 0 (IDLE), bus strobe in cycle 1, `done` in cycle 1 if `waitrequest`=0.
- Each `waitrequest` cycle adds one cycle. There is no timeout.
- Back-to-back: one idle bus cycle (IDLE) separates transfers. The bus throughput ceiling is one transfer per 2 cycles.
- Round-robin tie with `last_d`=1 grants I; then `last_d`=0, so the next tie grants D.
- `done` is never high for both ports in the same cycle.

## Structure
- Shared package `mips_bus_pkg`:
  - `arb_state_t` enum (IDLE, GRANT_I, GRANT_D).
  - `BYTEEN_ALL`=4'b1111.
  - Word-align mask constant.
- One sub-module, `bus_grant_picker`: combinational choice from (i_req, d_req, last_d, DATA_PRIORITY), one-hot 2-bit output. It is reused later for peripheral arbitration.

## Test plan
- Lone fetch: `i_req`=1, `i_address`=0xBFC0_0003, `waitrequest`=0, `readdata`=0x2402_0005 -> cycle 1 `read`=1, `address`=0xBFC0_0000, `byteenable`=1111, `i_done`=1, `i_readdata`=0x2402_0005.
- Store with stall: `d_req`=1, `d_write`=1, `d_address`=0x1000, `d_writedata`=0xDEAD_BEEF, `d_byteenable`=0011, `waitrequest` high for 3 cycles -> `write`=1 with stable fields for 4 cycles, `d_done` only in the 4th cycle, then `write`=0.
- Simultaneous requests, `DATA_PRIORITY`=1 -> D served first (`d_done`), I granted after one IDLE cycle. Repeat the tie -> D wins every time.
- Simultaneous requests, `DATA_PRIORITY`=0, three repeated ties -> grant order D, I, D.
- Reset asserted (low) while GRANT_D with `waitrequest`=1 -> `write`, `read`, `busy` go 0 without a clock edge. After release with no `req`: stays IDLE and no `done` pulse.
- Load during stall with `d_address`/`d_writedata` changed mid-grant -> bus `address`/`writedata` remain at their latched values.
